// File: rtl/pe_column_sequencer.sv
// Load/compute sequencer for one PE column: kernel load, neuron load, MAC steps, pipeline drain.
// Optional abort input is enabled by defining PE_SEQ_ABORT_EN.
module pe_column_sequencer #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int DRAIN = 2
) (
  input  logic         CLK,
  input  logic         RST,
`ifdef PE_SEQ_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic [A:0]   loadLen,
  input  logic [A:0]   computeLen,
  input  logic [W-1:0] dataIn,
  input  logic         dataValid,
  output logic         dataReady,
  output logic [W-1:0] kernelOut,
  output logic [W-1:0] neuronOut,
  output logic [7:0]   columnControl,
  output logic         busy,
  output logic         done,
  output logic         cfgError
);

  // state    | meaning
  // ST_IDLE  | waiting for start, lengths checked here
  // ST_CLR_K | clear address before kernel load
  // ST_LOAD_K| stream loadLen kernel words
  // ST_CLR_N | clear address before neuron load
  // ST_LOAD_N| stream loadLen neuron words
  // ST_CLR_C | clear address before compute
  // ST_COMP  | computeLen MAC steps, last one flagged
  // ST_DRAIN | DRAIN idle cycles to flush the PE pipeline
  // ST_DONE  | one-cycle done pulse
  typedef enum logic [3:0] {
    ST_IDLE, ST_CLR_K, ST_LOAD_K, ST_CLR_N, ST_LOAD_N,
    ST_CLR_C, ST_COMP, ST_DRAIN, ST_DONE
  } state_t;

  localparam logic [A:0] MAX_LEN   = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE       = {{A{1'b0}}, 1'b1};
  localparam logic [3:0] DRAIN_CNT = 4'(DRAIN);
  localparam logic [5:0] CS_CLR    = 6'h01;
  localparam logic [5:0] CS_INC    = 6'h02;
  localparam logic [5:0] CS_COMP   = 6'h04;
  localparam logic [5:0] CS_LAST   = 6'h0C;

  if (DRAIN < 1 || DRAIN > 15) begin : g_bad_drain
    $error("DRAIN must be in 1..15");
  end
  if (depth < 1) begin : g_bad_depth
    $error("depth must be at least 1");
  end

  state_t     r_state, w_next;
  logic [A:0] r_load_len, r_comp_len;
  logic [A:0] r_beat_cnt, r_step_cnt;
  logic [3:0] r_drain_cnt;
  logic       r_cfg_err;

  logic [5:0] w_ctrl;
  logic       w_kw, w_nw, w_ready, w_done;
  logic       w_len_ok, w_abort, w_start_ok;

  assign w_len_ok = (loadLen != '0) && (loadLen <= MAX_LEN) &&
                    (computeLen != '0) && (computeLen <= MAX_LEN);
  assign w_start_ok = (r_state == ST_IDLE) && start && w_len_ok;

`ifdef PE_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_ctrl  = 6'h00;
    w_kw    = 1'b0;
    w_nw    = 1'b0;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_CLR_K;
      ST_CLR_K: begin
        w_ctrl = CS_CLR;
        w_next = ST_LOAD_K;
      end
      ST_LOAD_K: begin
        w_ready = 1'b1;
        if (dataValid) begin
          w_kw   = 1'b1;
          w_ctrl = CS_INC;
          if (r_beat_cnt == ONE) w_next = ST_CLR_N;
        end
      end
      ST_CLR_N: begin
        w_ctrl = CS_CLR;
        w_next = ST_LOAD_N;
      end
      ST_LOAD_N: begin
        w_ready = 1'b1;
        if (dataValid) begin
          w_nw   = 1'b1;
          w_ctrl = CS_INC;
          if (r_beat_cnt == ONE) w_next = ST_CLR_C;
        end
      end
      ST_CLR_C: begin
        w_ctrl = CS_CLR;
        w_next = ST_COMP;
      end
      ST_COMP: begin
        if (r_step_cnt == ONE) begin
          w_ctrl = CS_LAST;
          w_next = ST_DRAIN;
        end else begin
          w_ctrl = CS_COMP;
        end
      end
      ST_DRAIN: if (r_drain_cnt == 4'd1) w_next = ST_DONE;
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Abort wins over everything, including the done pulse.
    if (w_abort) begin
      w_next  = ST_IDLE;
      w_ctrl  = 6'h00;
      w_kw    = 1'b0;
      w_nw    = 1'b0;
      w_ready = 1'b0;
      w_done  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_load_len  <= '0;
      r_comp_len  <= '0;
      r_beat_cnt  <= '0;
      r_step_cnt  <= '0;
      r_drain_cnt <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= (r_state == ST_IDLE) && start && !w_len_ok;
      if (w_start_ok) begin
        r_load_len <= loadLen;
        r_comp_len <= computeLen;
      end
      case (r_state)
        ST_CLR_K, ST_CLR_N: r_beat_cnt <= r_load_len;
        ST_LOAD_K, ST_LOAD_N: if (dataValid) r_beat_cnt <= r_beat_cnt - ONE;
        ST_CLR_C: begin
          r_step_cnt  <= r_comp_len;
          r_drain_cnt <= DRAIN_CNT;
        end
        ST_COMP: r_step_cnt <= r_step_cnt - ONE;
        ST_DRAIN: r_drain_cnt <= r_drain_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign columnControl = {w_ctrl, w_kw, w_nw};
  assign dataReady     = w_ready;
  assign done          = w_done;
  assign busy          = (r_state != ST_IDLE);
  assign cfgError      = r_cfg_err;
  assign kernelOut     = dataIn;
  assign neuronOut     = dataIn;

endmodule

// File: tb/tb_pe_column_sequencer.sv
// Scoreboard bench for pe_column_sequencer: stimulus pushes expected per-cycle outputs, monitor pops and compares.
module tb_pe_column_sequencer;
  localparam int A = 7;
  localparam int W = 16;
  localparam int DRAIN = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [A:0]   loadLen, computeLen;
  logic [W-1:0] dataIn;
  logic         dataValid;
  logic         dataReady;
  logic [W-1:0] kernelOut, neuronOut;
  logic [7:0]   columnControl;
  logic         busy, done, cfgError;
`ifdef PE_SEQ_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  pe_column_sequencer #(.depth(2), .A(A), .W(W), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RST(RST),
`ifdef PE_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .loadLen(loadLen), .computeLen(computeLen),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .kernelOut(kernelOut), .neuronOut(neuronOut),
    .columnControl(columnControl), .busy(busy), .done(done), .cfgError(cfgError)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] rec(bit b, bit d, bit e, bit r, logic [7:0] cc);
    return {b, d, e, r, cc};
  endfunction

  // Monitor: every cycle the DUT shows activity, pop one expected record.
  always @(negedge CLK) begin
    logic [11:0] act, exp;
    if (!RST && (busy || done || cfgError)) begin
      act = {busy, done, cfgError, dataReady, columnControl};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output act=%h (no expectation queued) t=%0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL scoreboard act=%h exp=%h t=%0t", act, exp, $time);
        end
      end
      checks++;
      if (kernelOut !== dataIn || neuronOut !== dataIn) begin
        failures++;
        $display("FAIL passthrough kernelOut=%h neuronOut=%h exp=%h", kernelOut, neuronOut, dataIn);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s leftover_expectations act=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({columnControl, dataReady, busy, done, cfgError} !== 12'h000) begin
      failures++;
      $display("FAIL %s outputs act=%h exp=000", name,
               {columnControl, dataReady, busy, done, cfgError});
    end
  endtask

  task automatic load_phase(input int ll, input bit bp, input logic [7:0] wr_cc,
                            input int abort_beat, output bit aborted);
    int beats = 0;
    int k = 0;
    bit v;
    logic [3:0] pat = 4'b1001;
    aborted = 1'b0;
    while (beats < ll) begin
      tick();
      v = bp ? pat[3 - (k % 4)] : 1'b1;
      dataValid = v;
      dataIn = W'($urandom);
`ifdef PE_SEQ_ABORT_EN
      if (k == abort_beat) begin
        abort = 1'b1;
        exp_q.push_back(rec(1, 0, 0, 0, 8'h00));
        tick();
        abort = 1'b0;
        dataValid = 1'b0;
        aborted = 1'b1;
        return;
      end
`endif
      exp_q.push_back(rec(1, 0, 0, 1, v ? wr_cc : 8'h00));
      if (v) beats++;
      k++;
    end
  endtask

  // rst_step: compute step at which RST is asserted (0 = never).
  // abort_beat: neuron-load cycle index at which abort is raised (-1 = never).
  task automatic run_job(input int ll, input int cl, input bit bp,
                         input int rst_step, input int abort_beat);
    bit aborted;
    loadLen = (A+1)'(ll);
    computeLen = (A+1)'(cl);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(rec(1, 0, 0, 0, 8'h04));
    load_phase(ll, bp, 8'h0A, -1, aborted);
    tick();
    dataValid = 1'b0;
    exp_q.push_back(rec(1, 0, 0, 0, 8'h04));
    load_phase(ll, bp, 8'h09, abort_beat, aborted);
    if (aborted) return;
    tick();
    dataValid = 1'b0;
    exp_q.push_back(rec(1, 0, 0, 0, 8'h04));
    for (int s = 1; s <= cl; s++) begin
      tick();
      if (s == rst_step) begin
        RST = 1'b1;
        #1;
        check_all_zero("reset_mid_compute");
        tick();
        RST = 1'b0;
        return;
      end
      // Start with a bad length while busy must be ignored.
      start = bp && (s == 1);
      if (bp) loadLen = '0;
      exp_q.push_back(rec(1, 0, 0, 0, (s == cl) ? 8'h30 : 8'h10));
    end
    for (int d = 0; d < DRAIN; d++) begin
      tick();
      start = 1'b0;
      exp_q.push_back(rec(1, 0, 0, 0, 8'h00));
    end
    tick();
    exp_q.push_back(rec(1, 1, 0, 0, 8'h00));
    tick();
  endtask

  task automatic bad_cfg(input int ll, input int cl);
    loadLen = (A+1)'(ll);
    computeLen = (A+1)'(cl);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(rec(0, 0, 1, 0, 8'h00));
    tick();
    tick();
    check_empty("bad_cfg");
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b1;
    loadLen = 8'd3;
    computeLen = 8'd4;
    dataIn = '0;
    dataValid = 1'b1;
`ifdef PE_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check_all_zero("reset_state");
    start = 1'b0;
    dataValid = 1'b0;
    RST = 1'b0;
    tick();

    run_job(3, 4, 0, 0, -1);
    tick();
    check_empty("nominal");

    run_job(3, 4, 1, 0, -1);
    tick();
    check_empty("backpressure");

    run_job(5, 1, 1, 0, -1);
    tick();
    check_empty("backpressure_cl1");

    bad_cfg(0, 4);
    bad_cfg(3, 129);
    bad_cfg(129, 4);
    bad_cfg(3, 0);

    run_job(128, 128, 0, 0, -1);
    tick();
    check_empty("boundary_128");

    run_job(3, 4, 0, 2, -1);
    tick();
    check_empty("reset_job");
    run_job(2, 3, 0, 0, -1);
    tick();
    check_empty("after_reset");

`ifdef PE_SEQ_ABORT_EN
    run_job(3, 4, 0, 0, 1);
    tick();
    check_all_zero("abort_idle");
    tick();
    check_empty("abort");
    run_job(2, 2, 0, 0, -1);
    tick();
    check_empty("after_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
